// File: rtl/ex_muldiv_hilo_if.sv
// ex_muldiv_hilo_if -- issue/result bundle between the EX stage and the
// HI/LO execute unit.
//
// Handshake: the EX stage presents a bundle on valid_i/op_i/opa_i/opb_i with
// the forwarded hi_i/lo_i. The unit takes the bundle in any cycle where it is
// idle (busy_o=0) and no flush is pending. If the bundle needs more than one
// cycle, stallreq_o is raised in that same cycle and held until the result
// cycle. Inputs may change freely after acceptance. The result is a single
// whilo_o pulse with hi_o/lo_o valid only while whilo_o=1; hi_o/lo_o read 0
// otherwise. There is no back-pressure on the result.
//
// Signals (LANES lanes):
//   valid_i [LANES]     lane carries a live instruction
//   op_i    [4*LANES]   per-lane op code
//   opa_i   [32*LANES]  per-lane rs operand
//   opb_i   [32*LANES]  per-lane rt operand
//   hi_i/lo_i           forwarded HI/LO
//   stallreq_o          hold the pipeline
//   busy_o              unit not idle
//   whilo_o, hi_o, lo_o combined HI/LO write
interface ex_muldiv_hilo_if #(
  parameter int LANES = 2
);
  logic [LANES-1:0]    valid_i;
  logic [4*LANES-1:0]  op_i;
  logic [32*LANES-1:0] opa_i;
  logic [32*LANES-1:0] opb_i;
  logic [31:0]         hi_i;
  logic [31:0]         lo_i;
  logic                stallreq_o;
  logic                busy_o;
  logic                whilo_o;
  logic [31:0]         hi_o;
  logic [31:0]         lo_o;

  modport master (
    output valid_i, op_i, opa_i, opb_i, hi_i, lo_i,
    input  stallreq_o, busy_o, whilo_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, op_i, opa_i, opb_i, hi_i, lo_i,
    output stallreq_o, busy_o, whilo_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_hilo.sv
// ex_muldiv_hilo -- N-lane HI/LO execute unit (MULT/MULTU, DIV/DIVU,
// MADD/MADDU/MSUB/MSUBU, MTHI, MTLO). Lanes run serially in ascending order,
// each seeing the HI/LO left by the previous lane; one combined write per
// bundle.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush_i        kills the in-flight bundle / suppresses acceptance
//   bus (slave)    issue bundle in, stallreq/busy/whilo/hi/lo out
//   dbg_state_o    current FSM state (0 IDLE,1 SEL,2 MUL,3 DIV,4 DONE)
//
// Optional build macro: EARLY_DIV_EN -- zero-quotient shortcut in the first
// divide cycle when |dividend| < |divisor| or dividend == 0.
module ex_muldiv_hilo #(
  parameter int LANES    = 2,
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  ex_muldiv_hilo_if.slave    bus,
  output logic [2:0]         dbg_state_o
);
  localparam logic [3:0] OP_MULT = 4'd1, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MADD = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8, OP_MSUB = 4'd9, OP_MSUBU = 4'd10;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q;
  logic [LANES-1:0]  mask_q;
  logic [3:0]        op_q  [LANES];
  logic [31:0]       opa_q [LANES];
  logic [31:0]       opb_q [LANES];
  logic [31:0]       whi_q, wlo_q;
  logic [7:0]        mul_cnt_q;
  logic [5:0]        div_cnt_q;
  logic [31:0]       rem_q, quo_q;

  function automatic logic is_live(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MSUBU);
  endfunction

  // Accept decode. A bundle made only of MTHI/MTLO is resolved in the
  // accept cycle, applying lanes in order on top of the forwarded HI/LO.
  logic [LANES-1:0] pend;
  logic             only_mt;
  logic [31:0]      zl_hi, zl_lo;
  always_comb begin
    pend    = '0;
    only_mt = 1'b1;
    zl_hi   = bus.hi_i;
    zl_lo   = bus.lo_i;
    for (int l = 0; l < LANES; l++) begin
      pend[l] = bus.valid_i[l] && is_live(bus.op_i[4*l +: 4]);
      if (pend[l]) begin
        if (bus.op_i[4*l +: 4] == OP_MTHI)      zl_hi = bus.opa_i[32*l +: 32];
        else if (bus.op_i[4*l +: 4] == OP_MTLO) zl_lo = bus.opa_i[32*l +: 32];
        else                                     only_mt = 1'b0;
      end
    end
  end

  logic accept_go, zl_go, mc_go;
  assign accept_go = (state_q == S_IDLE) && !rst && !flush_i && (|pend);
  assign zl_go     = accept_go && only_mt;
  assign mc_go     = accept_go && !only_mt;

  // Lowest pending lane and its latched operands.
  logic [IW-1:0]    sel_idx;
  logic [LANES-1:0] mask_clr;
  logic [3:0]       cur_op;
  logic [31:0]      cur_a, cur_b;
  always_comb begin
    sel_idx = '0;
    for (int l = LANES-1; l >= 0; l--) begin
      if (mask_q[l]) sel_idx = IW'(l);
    end
    mask_clr          = mask_q;
    mask_clr[sel_idx] = 1'b0;
    cur_op            = op_q[sel_idx];
    cur_a             = opa_q[sel_idx];
    cur_b             = opb_q[sel_idx];
  end

  // Finishing an op goes straight to DONE when no lanes remain, so a lone
  // op costs exactly SEL + its execute cycles + DONE.
  state_t next_after;
  assign next_after = (mask_clr == '0) ? S_DONE : S_SEL;

  // Multiply / multiply-accumulate (modulo 2^64).
  logic        mul_signed, mul_done;
  logic [63:0] ext_a, ext_b, prod, mul_res;
  always_comb begin
    mul_signed = (cur_op == OP_MULT) || (cur_op == OP_MADD) || (cur_op == OP_MSUB);
    ext_a      = mul_signed ? {{32{cur_a[31]}}, cur_a} : {32'b0, cur_a};
    ext_b      = mul_signed ? {{32{cur_b[31]}}, cur_b} : {32'b0, cur_b};
    prod       = ext_a * ext_b;
    case (cur_op)
      OP_MADD, OP_MADDU: mul_res = {whi_q, wlo_q} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {whi_q, wlo_q} - prod;
      default:           mul_res = prod;
    endcase
  end
  assign mul_done = (mul_cnt_q == 8'(MUL_LAT - 1));

  // Restoring divide on magnitudes. The first DIV cycle already performs
  // iteration 1 from the absolutized operands; the cycle after the last
  // iteration applies the signs.
  logic        div_signed, a_neg, b_neg, div_first, div_fix, div_zero, div_early;
  logic [31:0] abs_a, abs_b, it_rem, it_quo, rem_d, quo_d, fix_q, fix_r;
  logic [32:0] rem_sh, diff;
  always_comb begin
    div_signed = (cur_op == OP_DIV);
    a_neg      = div_signed && cur_a[31];
    b_neg      = div_signed && cur_b[31];
    abs_a      = a_neg ? -cur_a : cur_a;
    abs_b      = b_neg ? -cur_b : cur_b;
    div_first  = (div_cnt_q == 6'd0);
    div_fix    = (div_cnt_q == 6'(DIV_ITER));
    it_rem     = div_first ? 32'd0 : rem_q;
    it_quo     = div_first ? abs_a : quo_q;
    rem_sh     = {it_rem, it_quo[31]};
    diff       = rem_sh - {1'b0, abs_b};
    if (!diff[32]) begin
      rem_d = diff[31:0];
      quo_d = {it_quo[30:0], 1'b1};
    end else begin
      rem_d = rem_sh[31:0];
      quo_d = {it_quo[30:0], 1'b0};
    end
    fix_q    = (a_neg ^ b_neg) ? -quo_q : quo_q;
    fix_r    = a_neg ? -rem_q : rem_q;
    div_zero = div_first && (cur_b == 32'd0);
`ifdef EARLY_DIV_EN
    div_early = div_first && ((cur_a == 32'd0) || (abs_a < abs_b));
`else
    div_early = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      whi_q     <= '0;
      wlo_q     <= '0;
      mul_cnt_q <= '0;
      div_cnt_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      for (int l = 0; l < LANES; l++) begin
        op_q[l]  <= '0;
        opa_q[l] <= '0;
        opb_q[l] <= '0;
      end
    end else if (flush_i) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mc_go) begin
            state_q <= S_SEL;
            mask_q  <= pend;
            whi_q   <= bus.hi_i;
            wlo_q   <= bus.lo_i;
            for (int l = 0; l < LANES; l++) begin
              op_q[l]  <= bus.op_i[4*l +: 4];
              opa_q[l] <= bus.opa_i[32*l +: 32];
              opb_q[l] <= bus.opb_i[32*l +: 32];
            end
          end
        end
        S_SEL: begin
          mul_cnt_q <= '0;
          div_cnt_q <= '0;
          if (mask_q == '0) begin
            state_q <= S_DONE;
          end else begin
            case (cur_op)
              OP_MTHI: begin
                whi_q   <= cur_a;
                mask_q  <= mask_clr;
                state_q <= next_after;
              end
              OP_MTLO: begin
                wlo_q   <= cur_a;
                mask_q  <= mask_clr;
                state_q <= next_after;
              end
              OP_DIV, OP_DIVU: state_q <= S_DIV;
              default:         state_q <= S_MUL;
            endcase
          end
        end
        S_MUL: begin
          if (mul_done) begin
            {whi_q, wlo_q} <= mul_res;
            mask_q         <= mask_clr;
            state_q        <= next_after;
          end else begin
            mul_cnt_q <= mul_cnt_q + 8'd1;
          end
        end
        S_DIV: begin
          if (div_zero) begin
            whi_q   <= cur_a;
            wlo_q   <= 32'hFFFF_FFFF;
            mask_q  <= mask_clr;
            state_q <= next_after;
          end else if (div_early) begin
            whi_q   <= cur_a;
            wlo_q   <= 32'd0;
            mask_q  <= mask_clr;
            state_q <= next_after;
          end else if (div_fix) begin
            whi_q   <= fix_r;
            wlo_q   <= fix_q;
            mask_q  <= mask_clr;
            state_q <= next_after;
          end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_cnt_q <= div_cnt_q + 6'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result and stall are combinational so the zero-latency write and the
  // accept-cycle stall land in the same cycle; flush and reset win.
  always_comb begin
    bus.whilo_o    = 1'b0;
    bus.hi_o       = 32'd0;
    bus.lo_o       = 32'd0;
    bus.stallreq_o = 1'b0;
    if (!rst && !flush_i) begin
      if (state_q == S_DONE) begin
        bus.whilo_o = 1'b1;
        bus.hi_o    = whi_q;
        bus.lo_o    = wlo_q;
      end else if (zl_go) begin
        bus.whilo_o = 1'b1;
        bus.hi_o    = zl_hi;
        bus.lo_o    = zl_lo;
      end
      if (mc_go || state_q == S_SEL || state_q == S_MUL || state_q == S_DIV) begin
        bus.stallreq_o = 1'b1;
      end
    end
  end

  assign bus.busy_o  = (state_q != S_IDLE);
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ex_muldiv_hilo.sv
module tb_ex_muldiv_hilo;
  localparam int LANES = 2;
  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MADD = 4'd7, MADDU = 4'd8;
  localparam logic [3:0] MSUB = 4'd9, MSUBU = 4'd10;
  localparam logic [2:0] ST_IDLE = 3'd0;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  ex_muldiv_hilo_if #(.LANES(LANES)) bus();

  ex_muldiv_hilo #(.LANES(LANES), .MUL_LAT(2), .DIV_ITER(32)) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int whilo_cyc = -1;
  int pulse_cnt = 0;
  int stall_cnt = 0;
  logic acc_whilo, acc_stall;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.stallreq_o === 1'b1) stall_cnt++;
    if (bus.whilo_o === 1'b1) begin
      pulse_cnt++;
      whilo_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_whilo: got hi=0x%0h lo=0x%0h expected no write",
                 bus.hi_o, bus.lo_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("hilo_write", {bus.hi_o, bus.lo_o}, mon_e);
      end
    end
  end

  // drivers
  task automatic idle_inputs();
    bus.valid_i = '0;
    bus.op_i    = '0;
    bus.opa_i   = {LANES{32'hDEAD_BEEF}};
    bus.opb_i   = {LANES{32'hC0FF_EE11}};
    bus.hi_i    = 32'h5A5A_5A5A;
    bus.lo_i    = 32'hA5A5_A5A5;
  endtask

  task automatic send(input logic [1:0] v,
                      input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [31:0] hi, input logic [31:0] lo);
    @(posedge clk); #1;
    bus.valid_i = v;
    bus.op_i    = {o1, o0};
    bus.opa_i   = {a1, a0};
    bus.opb_i   = {b1, b0};
    bus.hi_i    = hi;
    bus.lo_i    = lo;
    acc_cyc     = cyc;
    stall_cnt   = 0;
    pulse_cnt   = 0;
    @(negedge clk);
    acc_whilo = bus.whilo_o;
    acc_stall = bus.stallreq_o;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d writes pending after %0d cycles expected 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy_o, 0);
    check("rst_whilo", bus.whilo_o, 0);
    check("rst_hi", bus.hi_o, 0);
    check("rst_lo", bus.lo_o, 0);
    check("rst_stall", bus.stallreq_o, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // MULT -2 * 3; lane1 invalid and must be ignored
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    send(2'b01, MULT, 32'hFFFF_FFFE, 32'd3, MULT, 32'd7, 32'd7, 32'd0, 32'd0);
    check("mult_acc_stall", acc_stall, 1);
    wait_done("mult", 20);
    check("mult_stall_cycles", stall_cnt, 4);
    check("mult_latency", whilo_cyc - acc_cyc, 4);
    check("mult_pulses", pulse_cnt, 1);

    // MTHI + MTLO, zero latency
    exp_q.push_back({32'h1234_5678, 32'h9ABC_DEF0});
    send(2'b11, MTHI, 32'h1234_5678, 32'd0, MTLO, 32'h9ABC_DEF0, 32'd0, 32'h1111_1111, 32'h2222_2222);
    check("mt_acc_whilo", acc_whilo, 1);
    check("mt_acc_stall", acc_stall, 0);
    wait_done("mt", 5);
    check("mt_latency", whilo_cyc - acc_cyc, 0);

    // op 12 acts as NONE; lone MTLO keeps forwarded HI
    exp_q.push_back({32'h3333_4444, 32'h0BAD_F00D});
    send(2'b11, 4'd12, 32'hFFFF_0000, 32'd0, MTLO, 32'h0BAD_F00D, 32'd0, 32'h3333_4444, 32'h5555_6666);
    check("mtlo_acc_whilo", acc_whilo, 1);
    wait_done("mtlo", 5);

    // empty mask: nothing happens
    send(2'b11, NONE, 32'd1, 32'd1, 4'd15, 32'd2, 32'd2, 32'd0, 32'd0);
    check("empty_whilo", acc_whilo, 0);
    check("empty_stall", acc_stall, 0);
    @(negedge clk);
    check("empty_busy", bus.busy_o, 0);

    // DIV -7 / 2
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    send(2'b01, DIV, 32'hFFFF_FFF9, 32'd2, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done("div_neg", 60);
    check("div_latency", whilo_cyc - acc_cyc, 35);
    check("div_stall_cycles", stall_cnt, 35);

    // DIVU 3 / 10
    exp_q.push_back({32'd3, 32'd0});
    send(2'b01, DIVU, 32'd3, 32'd10, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done("divu_small", 60);
`ifdef EARLY_DIV_EN
    check("divu_small_latency", whilo_cyc - acc_cyc, 3);
`else
    check("divu_small_latency", whilo_cyc - acc_cyc, 35);
`endif

    // divide by zero
    exp_q.push_back({32'hFFFF_FF00, 32'hFFFF_FFFF});
    send(2'b01, DIV, 32'hFFFF_FF00, 32'd0, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done("div_zero", 10);
    check("div_zero_latency", whilo_cyc - acc_cyc, 3);

    // signed overflow 0x80000000 / -1
    exp_q.push_back({32'd0, 32'h8000_0000});
    send(2'b01, DIV, 32'h8000_0000, 32'hFFFF_FFFF, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done("div_ovf", 60);

    // DIVU 0xFFFFFFFF / 16, then DIV 7 / -2
    exp_q.push_back({32'h0000_000F, 32'h0FFF_FFFF});
    send(2'b01, DIVU, 32'hFFFF_FFFF, 32'd16, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done("divu_big", 60);
    exp_q.push_back({32'd1, 32'hFFFF_FFFD});
    send(2'b01, DIV, 32'd7, 32'hFFFF_FFFE, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done("div_negb", 60);

    // MULTU 5x6 then MADDU 2x3 chained
    exp_q.push_back({32'd0, 32'd36});
    send(2'b11, MULTU, 32'd5, 32'd6, MADDU, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("chain", 30);
    check("chain_pulses", pulse_cnt, 1);
    check("chain_latency", whilo_cyc - acc_cyc, 7);

    // MTLO then MSUB: {0,10} - 12
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
    send(2'b11, MTLO, 32'd10, 32'd0, MSUB, 32'd3, 32'd4, 32'd0, 32'h999);
    wait_done("mtlo_msub", 30);
    check("mtlo_msub_latency", whilo_cyc - acc_cyc, 5);

    // MADD on forwarded HI/LO: 0x1_FFFFFFFF + (-1*2)
    exp_q.push_back({32'd1, 32'hFFFF_FFFD});
    send(2'b01, MADD, 32'hFFFF_FFFF, 32'd2, NONE, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF);
    wait_done("madd", 20);

    // MSUBU: 0 - 0xFFFFFFFF^2
    exp_q.push_back({32'd1, 32'hFFFF_FFFF});
    send(2'b01, MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done("msubu", 20);

    // flush during DIV iteration 10
    send(2'b01, DIV, 32'd1000, 32'd7, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush_pre_stall", bus.stallreq_o, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", bus.stallreq_o, 0);
    check("flush_whilo", bus.whilo_o, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", bus.busy_o, 0);
    check("flush_state", dbg_state, ST_IDLE);
    exp_q.push_back({32'd0, 32'd56});
    send(2'b01, MULTU, 32'd7, 32'd8, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_done("post_flush", 20);
    check("post_flush_latency", whilo_cyc - acc_cyc, 4);

    // reset mid-MUL
    send(2'b01, MULT, 32'd5, 32'd5, NONE, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_mul_busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_stall", bus.stallreq_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", bus.busy_o, 0);
    check("rst_mid_whilo", bus.whilo_o, 0);
    check("rst_mid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("rst_mid_stall2", bus.stallreq_o, 0);
    check("rst_mid_state", dbg_state, ST_IDLE);
    repeat (6) @(posedge clk);

    exp_q.push_back({32'hCAFE_0001, 32'h0000_0002});
    send(2'b01, MTHI, 32'hCAFE_0001, 32'd0, NONE, 32'd0, 32'd0, 32'd9, 32'd2);
    wait_done("post_rst", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
